btn_event_arbiter: RTL and testbench

- Front-end controller for the board push-buttons (BTNR, BTNU, BTND, BTNL).
- Synchronises, debounces and edge-detects all four buttons, then arbitrates simultaneous presses by fixed priority.
- Queues the resulting press events in a small FIFO and hands them to the top-level game/control FSM one at a time over a valid/ready handshake.
- Replaces per-FSM ad-hoc debounce logic, so exactly one consumer owns the button resource.

---
 rtl/btn_event_arbiter_if.sv | 12 +
 rtl/btn_event_arbiter.sv | 121 ++++++++++++
 tb/tb_btn_event_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/btn_event_arbiter_if.sv
// Event handshake between the button front-end (master) and its single consumer (slave).
interface btn_event_arbiter_if #(
    parameter int CW = 3
);
    logic          ev_valid;
    logic          ev_ready;
    logic [1:0]    ev_code;
    logic [CW-1:0] ev_count;

    modport master (output ev_valid, ev_code, ev_count, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_count, output ev_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// Button front-end: per-button sync + debounce lanes, rising-edge pending bits,
// fixed-priority arbiter (U > D > L > R) feeding a small event FIFO.
module btn_event_arbiter_lane #(
    parameter int DB_CYCLES = 1000,
    parameter int CNT_W     = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o
);
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            // Accept the new level on the cycle the count would hit DB_CYCLES.
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) level_d = ~level_q;
            else                                 cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule

module btn_event_arbiter #(
    parameter int DB_CYCLES  = 1000,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  btn_in,
    input  logic                        clr_ovf,
    output logic [3:0]                  btn_level,
    output logic                        ovf,
    btn_event_arbiter_if.master         ev
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]                  lvl_prev_q;
    logic [3:0]                  pend_q, pend_d;
    logic [3:0]                  rise, grant;
    logic [1:0]                  sel;
    logic                        ovf_q, ovf_d;
    logic [FIFO_DEPTH-1:0][1:0]  mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q, count_d;
    logic                        push, pop, push_ok;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        btn_event_arbiter_lane #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn_in[i]),
            .level_o (btn_level[i])
        );
    end

    assign rise    = btn_level & ~lvl_prev_q;
    assign pop     = ev.ev_valid & ev.ev_ready;
    assign push_ok = (count_q != CW'(FIFO_DEPTH)) | pop;
    assign push    = (|pend_q) & push_ok;

    always_comb begin
        sel   = 2'd0;
        grant = '0;
        if      (pend_q[1]) sel = 2'd1;
        else if (pend_q[2]) sel = 2'd2;
        else if (pend_q[3]) sel = 2'd3;
        if (push) grant[sel] = 1'b1;
    end

    // A new rise wins over a same-cycle grant; a rise on a still-held bit is a lost press.
    assign pend_d  = (pend_q & ~grant) | rise;
    assign ovf_d   = (|(rise & pend_q & ~grant)) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_prev_q <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            lvl_prev_q <= btn_level;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= sel;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign ev.ev_valid = (count_q != '0);
    assign ev.ev_code  = mem_q[rd_ptr_q];
    assign ev.ev_count = count_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench: stimulus pushes expected codes, a negedge monitor pops and compares on each handshake.
module tb_btn_event_arbiter;
    localparam int DB = 8, DEPTH = 4, CW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_in = '0;
    logic       clr_ovf = 1'b0;
    logic [3:0] btn_level;
    logic       ovf;

    btn_event_arbiter_if #(.CW(CW)) ev_if ();

    btn_event_arbiter #(.DB_CYCLES(DB), .FIFO_DEPTH(DEPTH), .CNT_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .clr_ovf   (clr_ovf),
        .btn_level (btn_level),
        .ovf       (ovf),
        .ev        (ev_if.master)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e;
    bit         t5_on = 0, t5_long = 0, prev_v = 0;
    int         t5_max = 0;
    bit         quiet_on = 0, quiet_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst && ev_if.ev_valid && ev_if.ev_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got code %0d expected none (t=%0t)", ev_if.ev_code, $time);
            end else begin
                e = exp_q.pop_front();
                check("pop_code", 32'(ev_if.ev_code), 32'(e));
            end
        end
        if (t5_on) begin
            if (int'(ev_if.ev_count) > t5_max) t5_max = int'(ev_if.ev_count);
            if (prev_v && ev_if.ev_valid) t5_long = 1;
            prev_v = ev_if.ev_valid;
        end
        if (quiet_on && (ev_if.ev_valid || btn_level[1])) quiet_bad = 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int i);
        btn_in[i] = 1'b1;
        cyc(14);
        btn_in[i] = 1'b0;
        cyc(14);
    endtask

    task automatic drain(input string name);
        int k = 0;
        ev_if.ev_ready = 1'b1;
        while ((ev_if.ev_count != 0 || exp_q.size() != 0) && k < 200) begin
            cyc(1);
            k++;
        end
        check({name, "_drain_done"}, 32'(k < 200), 32'd1);
        ev_if.ev_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_if.ev_ready = 1'b0;
        cyc(3);
        @(negedge clk);
        check("rst_valid", 32'(ev_if.ev_valid), 0);
        check("rst_count", 32'(ev_if.ev_count), 0);
        check("rst_code",  32'(ev_if.ev_code), 0);
        check("rst_level", 32'(btn_level), 0);
        check("rst_ovf",   32'(ovf), 0);
        @(posedge clk); #1 rst = 1'b1;
        cyc(2);

        // 1: single held press, latency DB+4
        btn_in[0] = 1'b1;
        exp_q.push_back(2'd0);
        repeat (9) @(posedge clk);
        @(negedge clk); check("t1_level_e9",  32'(btn_level[0]), 0);
        @(negedge clk); check("t1_level_e10", 32'(btn_level[0]), 1);
        @(negedge clk); check("t1_valid_e11", 32'(ev_if.ev_valid), 0);
        @(negedge clk);
        check("t1_valid_e12", 32'(ev_if.ev_valid), 1);
        check("t1_count_e12", 32'(ev_if.ev_count), 1);
        check("t1_code_e12",  32'(ev_if.ev_code), 0);
        repeat (38) @(negedge clk);
        check("t1_one_event", 32'(ev_if.ev_count), 1);
        @(posedge clk); #1 btn_in[0] = 1'b0;
        cyc(14);
        drain("t1");

        // 2: glitches shorter than DB_CYCLES
        quiet_on = 1;
        repeat (6) begin
            btn_in[1] = 1'b1; cyc(5);
            btn_in[1] = 1'b0; cyc(5);
        end
        cyc(12);
        quiet_on = 0;
        check("t2_glitch_quiet", 32'(quiet_bad), 0);

        // 3: simultaneous presses, priority order
        btn_in = 4'hF;
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        cyc(16);
        check("t3_count_full", 32'(ev_if.ev_count), 4);
        btn_in = 4'h0;
        cyc(14);
        drain("t3");

        // 4: full FIFO, held pending, overflow
        repeat (4) begin
            exp_q.push_back(2'd0);
            press(0);
        end
        check("t4_count_full", 32'(ev_if.ev_count), 4);
        check("t4_ovf_clear",  32'(ovf), 0);
        exp_q.push_back(2'd1);
        press(1);
        check("t4_count_held", 32'(ev_if.ev_count), 4);
        check("t4_ovf_held",   32'(ovf), 0);
        press(1);
        check("t4_ovf_set",    32'(ovf), 1);
        check("t4_count_ovf",  32'(ev_if.ev_count), 4);
        drain("t4");
        check("t4_ovf_sticky", 32'(ovf), 1);
        clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
        check("t4_ovf_cleared", 32'(ovf), 0);

        // 5: consumer always ready
        ev_if.ev_ready = 1'b1;
        prev_v = 0; t5_on = 1;
        exp_q.push_back(2'd0);
        press(0);
        cyc(72);
        exp_q.push_back(2'd1);
        press(1);
        cyc(5);
        t5_on = 0;
        ev_if.ev_ready = 1'b0;
        check("t5_max_count",   32'(t5_max), 1);
        check("t5_valid_1cyc",  32'(t5_long), 0);
        check("t5_sb_empty",    32'(exp_q.size()), 0);

        // 6: asynchronous reset mid-operation
        press(0);
        btn_in[2] = 1'b1;
        cyc(14);
        check("t6_count_2",  32'(ev_if.ev_count), 2);
        check("t6_level_d",  32'(btn_level[2]), 1);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(ev_if.ev_valid), 0);
        check("t6_rst_count", 32'(ev_if.ev_count), 0);
        check("t6_rst_level", 32'(btn_level), 0);
        check("t6_rst_ovf",   32'(ovf), 0);
        exp_q.delete();
        btn_in = 4'h0;
        @(posedge clk); #1 rst = 1'b1;
        quiet_bad = 0; quiet_on = 1;
        cyc(40);
        quiet_on = 0;
        check("t6_no_events", 32'(quiet_bad), 0);
        check("t6_count_0",   32'(ev_if.ev_count), 0);

        check("sb_empty_end", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
